csi2_rx_frame_ctrl: RTL
=======================

// Module: csi2_rx_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the CSI-2 receive path. Drives the packet converter's enable,
//  and sniffs its AXI4-Stream output to track Frame Start/Frame End short packets on one
//  virtual channel. Starts and stops reception only on frame boundaries, counts lines per
//  frame, counts PHY errors and aborts frames stalled by a watchdog. Sits beside the
//  converter; status outputs feed the CSR block.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  idle cycles inside a frame before abort (>=2)
//  TIMEOUT_W       $clog2(TIMEOUT_CYCLES+1)  watchdog counter width (derived, do not override)
//  FRAME_CNT_W     32         completed-frame counter width, wraps
//  ERR_CNT_W       16         PHY error counter width, saturates
// PORTS
//  clk_i            in   1   byte clock domain of converter
//  srst_i           in   1   reset, asynchronous, active-high
//  sw_enable_i      in   1   software run request (level)
//  cfg_vc_i         in   2   virtual channel to track
//  error_i          in   1   PHY error strobe, same as converter error input
//  pkt_tvalid_i     in   1   converter stream tvalid (monitor only, no backpressure)
//  pkt_tdata_i      in   32  converter stream tdata
//  pkt_tlast_i      in   1   converter stream tlast
//  rx_enable_o      out  1   to converter enable_i
//  frame_active_o   out  1   high between accepted FS and FE/abort
//  frame_start_o    out  1   1-cycle pulse on accepted FS
//  frame_done_o     out  1   1-cycle pulse on frame close (FE, FS-restart or timeout)
//  frame_err_o      out  1   qualifies frame_done_o: frame was corrupted
//  frame_num_o      out  16  frame number captured from FS word count
//  frame_lines_o    out  16  long-packet count of last closed frame
//  frame_cnt_o      out  FRAME_CNT_W  frames closed without error
//  err_cnt_o        out  ERR_CNT_W    error_i cycles while rx_enable_o=1
//  timeout_o        out  1   1-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: every output 0; state IDLE; sop flag 1; all counters 0.
//  Header decode: sop<=1 on tvalid&tlast, sop<=0 on tvalid&!tlast. Header beat = tvalid&sop.
//   Fields: DT=[5:0], VC=[7:6], WC=[23:8]. Beats with VC!=cfg_vc_i are ignored.
//   FS = header & DT==0x00; FE = DT==0x01; LINE = DT>=0x10.
//  FSM (all outputs registered, 1-cycle latency from the decoding beat):
//   IDLE:     rx_enable_o=0. sw_enable_i=1 -> WAIT_FS.
//   WAIT_FS:  rx_enable_o=1; LINE/FE ignored. FS -> IN_FRAME, frame_start_o, frame_num_o<=WC,
//             line cnt<=0. sw_enable_i=0 -> IDLE.
//   IN_FRAME: frame_active_o=1; LINE increments line cnt (saturate 0xFFFF). sw_enable_i=0 only
//             sets stop_pending; no abort mid-frame.
//    FE: frame_done_o, frame_lines_o<=line cnt, frame_err_o=err_seen; frame_cnt_o++ if !err_seen;
//        -> IDLE if stop_pending|!sw_enable_i else WAIT_FS.
//    FS (no FE): close with frame_err_o=1, then immediately open the new frame (start pulse
//        same cycle as done pulse, frame_num_o updated, line cnt<=0), stay IN_FRAME.
//    Watchdog: cnt clears on any tvalid, else increments; at TIMEOUT_CYCLES -> timeout_o,
//        frame_done_o with frame_err_o=1, -> WAIT_FS (or IDLE if stopping). tvalid same cycle wins.
//  error_i while rx_enable_o=1: err_cnt_o++ saturating at all-ones; in IN_FRAME sets err_seen
//   (cleared on frame open). error_i coincident with FE marks that frame erroneous.
//  stop_pending cleared on leaving IN_FRAME and when sw_enable_i reasserts.
//  Async reset mid-frame: outputs drop to 0 immediately; converter is disabled.
// STRUCTURE
//  csi2_pkg: DT constants (CSI2_DT_FS, _FE, _LS, _LE, CSI2_DT_LONG_MIN=6'h10), header field
//  bit ranges, state enum typedef csi2_frame_state_t. Single module, no sub-modules.
// TESTING
//  1 enable; FS(WC=5), 3 long pkts, FE -> start pulse, done pulse, lines=3, num=5, frame_cnt=1, err=0.
//  2 enable mid-frame: 2 long pkts then FE then FS,1 long,FE -> only 2nd frame counted, lines=1.
//  3 sw_enable_i low after FS -> rx_enable_o stays 1 until FE, 0 the cycle after FE's done pulse.
//  4 TIMEOUT_CYCLES=16, stall after FS -> timeout_o on 16th idle cycle, done err=1, frame_cnt unchanged.
//  5 FS,long,FS,long,FE -> two done pulses (err=1 then 0), frame_cnt=1; ERR_CNT_W=2, 5 error_i -> 3.
//  6 packets on VC!=cfg_vc_i ignored; srst_i asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/csi2_rx_frame_ctrl_pkg.sv
// Shared definitions for the CSI-2 receive frame controller: data types,
// packet header field positions and the frame sequencer state encoding.
package csi2_rx_frame_ctrl_pkg;

  localparam logic [5:0] CSI2_DT_FS       = 6'h00;
  localparam logic [5:0] CSI2_DT_FE       = 6'h01;
  localparam logic [5:0] CSI2_DT_LS       = 6'h02;
  localparam logic [5:0] CSI2_DT_LE       = 6'h03;
  localparam logic [5:0] CSI2_DT_LONG_MIN = 6'h10;

  localparam int CSI2_DT_LSB = 0;
  localparam int CSI2_DT_MSB = 5;
  localparam int CSI2_VC_LSB = 6;
  localparam int CSI2_VC_MSB = 7;
  localparam int CSI2_WC_LSB = 8;
  localparam int CSI2_WC_MSB = 23;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_FS  = 2'd1,
    ST_IN_FRAME = 2'd2
  } csi2_frame_state_t;

endpackage

// File: rtl/csi2_rx_frame_ctrl_if.sv
// AXI4-Stream view of the packet converter output; the frame controller only
// monitors it, so there is no tready.
interface csi2_rx_frame_ctrl_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;

  modport master (output tvalid, tdata, tlast);
  modport slave  (input  tvalid, tdata, tlast);
endinterface

// File: rtl/csi2_rx_frame_ctrl.sv
// Frame-level sequencer for the CSI-2 receive path: gates the converter on frame
// boundaries, tracks FS/FE on one virtual channel, counts lines/errors, watchdog abort.
//
// state       | meaning
// ST_IDLE     | converter disabled, waiting for sw_enable_i
// ST_WAIT_FS  | converter enabled, discarding traffic until a Frame Start
// ST_IN_FRAME | inside a frame, counting lines, watchdog armed
module csi2_rx_frame_ctrl
  import csi2_rx_frame_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FRAME_CNT_W    = 32,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   sw_enable_i,
  input  logic [1:0]             cfg_vc_i,
  input  logic                   error_i,
  csi2_rx_frame_ctrl_if.slave    pkt,
  output logic                   rx_enable_o,
  output logic                   frame_active_o,
  output logic                   frame_start_o,
  output logic                   frame_done_o,
  output logic                   frame_err_o,
  output logic [15:0]            frame_num_o,
  output logic [15:0]            frame_lines_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o,
  output logic                   timeout_o
);

  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMEOUT_W-1:0] WD_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  csi2_frame_state_t      state_q;
  logic                   sop_q, stop_pending_q, err_seen_q;
  logic [15:0]            line_cnt_q;
  logic [TIMEOUT_W-1:0]   wd_q;
  logic                   rx_enable_q, frame_active_q, frame_start_q, frame_done_q;
  logic                   frame_err_q, timeout_q;
  logic [15:0]            frame_num_q, frame_lines_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic        hdr_beat, is_fs, is_fe, is_line, stopping, fe_err;

  assign hdr_dt   = pkt.tdata[CSI2_DT_MSB:CSI2_DT_LSB];
  assign hdr_vc   = pkt.tdata[CSI2_VC_MSB:CSI2_VC_LSB];
  assign hdr_wc   = pkt.tdata[CSI2_WC_MSB:CSI2_WC_LSB];
  assign hdr_beat = pkt.tvalid & sop_q & (hdr_vc == cfg_vc_i);
  assign is_fs    = hdr_beat & (hdr_dt == CSI2_DT_FS);
  assign is_fe    = hdr_beat & (hdr_dt == CSI2_DT_FE);
  assign is_line  = hdr_beat & (hdr_dt >= CSI2_DT_LONG_MIN);
  assign stopping = stop_pending_q | ~sw_enable_i;
  // An error on the FE beat itself still belongs to the closing frame.
  assign fe_err   = err_seen_q | error_i;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (error_i && rx_enable_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q        <= ST_IDLE;
      sop_q          <= 1'b1;
      stop_pending_q <= 1'b0;
      err_seen_q     <= 1'b0;
      line_cnt_q     <= '0;
      wd_q           <= '0;
      rx_enable_q    <= 1'b0;
      frame_active_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      timeout_q      <= 1'b0;
      frame_num_q    <= '0;
      frame_lines_q  <= '0;
      frame_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      err_cnt_q     <= err_cnt_d;
      if (pkt.tvalid) sop_q <= pkt.tlast;
      // Enable trails the state by a cycle so it is still high during the FE done pulse.
      rx_enable_q <= (state_q != ST_IDLE);

      case (state_q)
        ST_IDLE: begin
          if (sw_enable_i) state_q <= ST_WAIT_FS;
        end
        ST_WAIT_FS: begin
          if (!sw_enable_i) begin
            state_q <= ST_IDLE;
          end else if (is_fs) begin
            state_q        <= ST_IN_FRAME;
            frame_active_q <= 1'b1;
            frame_start_q  <= 1'b1;
            frame_num_q    <= hdr_wc;
            line_cnt_q     <= '0;
            err_seen_q     <= 1'b0;
            wd_q           <= WD_LOAD;
          end
        end
        ST_IN_FRAME: begin
          stop_pending_q <= ~sw_enable_i;
          if (error_i) err_seen_q <= 1'b1;
          if (is_line && (line_cnt_q != 16'hFFFF)) line_cnt_q <= line_cnt_q + 16'd1;
          if (pkt.tvalid)        wd_q <= WD_LOAD;
          else if (wd_q != '0)   wd_q <= wd_q - 1'b1;

          if (is_fe) begin
            frame_done_q   <= 1'b1;
            frame_err_q    <= fe_err;
            frame_lines_q  <= line_cnt_q;
            if (!fe_err) frame_cnt_q <= frame_cnt_q + 1'b1;
            frame_active_q <= 1'b0;
            stop_pending_q <= 1'b0;
            state_q        <= stopping ? ST_IDLE : ST_WAIT_FS;
          end else if (is_fs) begin
            // Missing FE: close the old frame as corrupted and open the new one.
            frame_done_q   <= 1'b1;
            frame_err_q    <= 1'b1;
            frame_lines_q  <= line_cnt_q;
            frame_start_q  <= 1'b1;
            frame_num_q    <= hdr_wc;
            line_cnt_q     <= '0;
            err_seen_q     <= 1'b0;
          end else if (!pkt.tvalid && (wd_q == '0)) begin
            timeout_q      <= 1'b1;
            frame_done_q   <= 1'b1;
            frame_err_q    <= 1'b1;
            frame_lines_q  <= line_cnt_q;
            frame_active_q <= 1'b0;
            stop_pending_q <= 1'b0;
            state_q        <= stopping ? ST_IDLE : ST_WAIT_FS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_enable_o    = rx_enable_q;
  assign frame_active_o = frame_active_q;
  assign frame_start_o  = frame_start_q;
  assign frame_done_o   = frame_done_q;
  assign frame_err_o    = frame_err_q;
  assign frame_num_o    = frame_num_q;
  assign frame_lines_o  = frame_lines_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign err_cnt_o      = err_cnt_q;
  assign timeout_o      = timeout_q;

endmodule
